// File: rtl/decode_stage.sv
// decode_stage: registered, flow-controlled RV32I/M decode stage.
// Buffers fetched {instr, pc} pairs in a circular queue. It decodes the queue
// head into a control bundle and registers that bundle behind a valid/ready
// handshake. A one-cycle bubble is inserted on a load-use hazard, and flush
// drops all queued and registered work. Illegal encodings are flagged.
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   fetch_valid_i/ready_o       fetch handshake; fetch_instr_i, fetch_pc_i payload
//   flush_i                     kill queued and registered instructions
//   ex_ready_i / ex_valid_o     execute handshake; ex_pc_o and decoded control
//   illegal_o                   registered instruction is an illegal encoding
//   iq_count_o                  queue occupancy
module decode_stage #(
    parameter int IQ_DEPTH = 4,
    parameter bit EN_MEXT  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      fetch_valid_i,
    output logic                      fetch_ready_o,
    input  logic [31:0]               fetch_instr_i,
    input  logic [31:0]               fetch_pc_i,
    input  logic                      flush_i,
    input  logic                      ex_ready_i,
    output logic                      ex_valid_o,
    output logic [31:0]               ex_pc_o,
    output logic                      br_sig_o,
    output logic [2:0]                br_op_o,
    output logic [2:0]                lsu_op_o,
    output logic [4:0]                alu_op_o,
    output logic [1:0]                data_origin_o,
    output logic [1:0]                data_dest_o,
    output logic [31:0]               imm_o,
    output logic [4:0]                reg_addr1_o,
    output logic [4:0]                reg_addr2_o,
    output logic [4:0]                reg_wr_addr_o,
    output logic                      reg_wr_sig_o,
    output logic                      mem_wr_sig_o,
    output logic                      illegal_o,
    output logic [$clog2(IQ_DEPTH):0] iq_count_o
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // M-extension ops are ALU_MUL + funct3 (MUL..REMU map to 10..17).
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    // Conditional branches reuse funct3 as br_op; 2 and 3 are free for jumps.
    localparam logic [2:0] BR_JAL  = 3'd2;
    localparam logic [2:0] BR_JALR = 3'd3;

    localparam logic [1:0] ORIG_RR = 2'd0;  // rs1, rs2
    localparam logic [1:0] ORIG_RI = 2'd1;  // rs1, imm
    localparam logic [1:0] ORIG_PI = 2'd2;  // pc, imm

    localparam logic [1:0] DEST_NONE = 2'd0;
    localparam logic [1:0] DEST_ALU  = 2'd1;
    localparam logic [1:0] DEST_MEM  = 2'd2;
    localparam logic [1:0] DEST_LINK = 2'd3;  // rd <= pc + 4

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IQ_DEPTH);

    typedef struct packed {
        logic        br_sig;
        logic [2:0]  br_op;
        logic [2:0]  lsu_op;
        logic [4:0]  alu_op;
        logic [1:0]  origin;
        logic [1:0]  dest;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_wr;
        logic        illegal;
    } ctrl_t;

    logic [31:0]      iq_instr [IQ_DEPTH];
    logic [31:0]      iq_pc    [IQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       ld_rd;
    ctrl_t            ctrl_q, dec;
    logic             push, pop, advance, empty, hazard;
    logic             use_rs1, use_rs2, is_load, legal;

    logic [31:0] head;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;

    assign head   = iq_instr[rd_ptr];
    assign opcode = head[6:0];
    assign rd     = head[11:7];
    assign f3     = head[14:12];
    assign rs1    = head[19:15];
    assign rs2    = head[24:20];
    assign f7     = head[31:25];

    function automatic logic [4:0] base_alu(input logic [2:0] funct3);
        case (funct3)
            3'd0:    base_alu = ALU_ADD;
            3'd1:    base_alu = ALU_SLL;
            3'd2:    base_alu = ALU_SLT;
            3'd3:    base_alu = ALU_SLTU;
            3'd4:    base_alu = ALU_XOR;
            3'd5:    base_alu = ALU_SRL;
            3'd6:    base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_load = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.origin = ORIG_RI;  // x0 + imm
                dec.dest   = DEST_ALU;
                dec.imm    = {head[31:12], 12'b0};
                dec.reg_wr = 1'b1;
            end
            OPC_AUIPC: begin
                dec.origin = ORIG_PI;
                dec.dest   = DEST_ALU;
                dec.imm    = {head[31:12], 12'b0};
                dec.reg_wr = 1'b1;
            end
            OPC_JAL: begin
                dec.br_sig = 1'b1;
                dec.br_op  = BR_JAL;
                dec.origin = ORIG_PI;
                dec.dest   = DEST_LINK;
                dec.imm    = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
                dec.reg_wr = 1'b1;
            end
            OPC_JALR: begin
                legal      = (f3 == 3'd0);
                use_rs1    = 1'b1;
                dec.br_sig = 1'b1;
                dec.br_op  = BR_JALR;
                dec.origin = ORIG_RI;
                dec.dest   = DEST_LINK;
                dec.imm    = {{20{head[31]}}, head[31:20]};
                dec.reg_wr = 1'b1;
            end
            OPC_BRANCH: begin
                legal      = (f3 != 3'd2) && (f3 != 3'd3);
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.br_sig = 1'b1;
                dec.br_op  = f3;
                dec.origin = ORIG_RR;
                dec.dest   = DEST_NONE;
                dec.imm    = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
            end
            OPC_LOAD: begin
                legal      = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                use_rs1    = 1'b1;
                is_load    = 1'b1;
                dec.lsu_op = f3;
                dec.origin = ORIG_RI;
                dec.dest   = DEST_MEM;
                dec.imm    = {{20{head[31]}}, head[31:20]};
                dec.reg_wr = 1'b1;
            end
            OPC_STORE: begin
                legal      = f3 inside {3'd0, 3'd1, 3'd2};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.lsu_op = f3;
                dec.origin = ORIG_RI;
                dec.dest   = DEST_NONE;
                dec.imm    = {{20{head[31]}}, head[31:25], head[11:7]};
                dec.mem_wr = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rs1    = 1'b1;
                dec.alu_op = base_alu(f3);
                dec.origin = ORIG_RI;
                dec.dest   = DEST_ALU;
                dec.imm    = {{20{head[31]}}, head[31:20]};
                dec.reg_wr = 1'b1;
                // Shift amounts occupy imm[4:0]; the upper bits carry funct7.
                if (f3 == 3'd1) begin
                    legal   = (f7 == F7_BASE);
                    dec.imm = {27'b0, head[24:20]};
                end else if (f3 == 3'd5) begin
                    dec.imm = {27'b0, head[24:20]};
                    if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
                    else              legal      = (f7 == F7_BASE);
                end
            end
            OPC_OP: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.origin = ORIG_RR;
                dec.dest   = DEST_ALU;
                dec.reg_wr = 1'b1;
                if (f7 == F7_BASE)                     dec.alu_op = base_alu(f3);
                else if (f7 == F7_ALT && f3 == 3'd0)   dec.alu_op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'd5)   dec.alu_op = ALU_SRA;
                else if (f7 == F7_MEXT && EN_MEXT)     dec.alu_op = ALU_MUL + 5'(f3);
                else                                   legal      = 1'b0;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // Legal no-ops: the all-zero bundle.
            end
            default: legal = 1'b0;
        endcase
        dec.rs1 = use_rs1 ? rs1 : 5'd0;
        dec.rs2 = use_rs2 ? rs2 : 5'd0;
        dec.rd  = dec.reg_wr ? rd : 5'd0;
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign empty         = (count == '0);
    assign fetch_ready_o = (count != CNT_FULL) && !flush_i;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign advance       = !ex_valid_o || ex_ready_i;
    assign hazard        = !empty && (ld_rd != 5'd0) &&
                           ((use_rs1 && rs1 == ld_rd) || (use_rs2 && rs2 == ld_rd));
    assign pop           = advance && !empty && !hazard && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            iq_instr[wr_ptr] <= fetch_instr_i;
            iq_pc[wr_ptr]    <= fetch_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_valid_o <= 1'b0;
            ex_pc_o    <= '0;
            ctrl_q     <= '0;
            ld_rd      <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
            ld_rd      <= '0;
        end else if (advance) begin
            if (pop) begin
                ex_valid_o <= 1'b1;
                ex_pc_o    <= iq_pc[rd_ptr];
                ctrl_q     <= dec;
                ld_rd      <= (is_load && legal) ? rd : 5'd0;
            end else begin
                // Bubble: either nothing to issue or a load-use stall. The
                // stalled head issues on the next advance, so the hazard clears.
                ex_valid_o <= 1'b0;
                if (hazard) ld_rd <= '0;
            end
        end
    end

    assign br_sig_o      = ctrl_q.br_sig;
    assign br_op_o       = ctrl_q.br_op;
    assign lsu_op_o      = ctrl_q.lsu_op;
    assign alu_op_o      = ctrl_q.alu_op;
    assign data_origin_o = ctrl_q.origin;
    assign data_dest_o   = ctrl_q.dest;
    assign imm_o         = ctrl_q.imm;
    assign reg_addr1_o   = ctrl_q.rs1;
    assign reg_addr2_o   = ctrl_q.rs2;
    assign reg_wr_addr_o = ctrl_q.rd;
    assign reg_wr_sig_o  = ctrl_q.reg_wr;
    assign mem_wr_sig_o  = ctrl_q.mem_wr;
    assign illegal_o     = ctrl_q.illegal;
    assign iq_count_o    = count;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage (IQ_DEPTH=4).
// u_dut decodes the M extension; u_dut_nm (EN_MEXT=0) shares the same inputs
// and is checked where the two builds must differ.
module tb_decode_stage;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_MUL   = 5'd10;
    localparam logic [1:0] ORIG_RR   = 2'd0;
    localparam logic [1:0] ORIG_RI   = 2'd1;
    localparam logic [1:0] DEST_NONE = 2'd0;
    localparam logic [1:0] DEST_ALU  = 2'd1;
    localparam logic [1:0] DEST_MEM  = 2'd2;

    logic        clk_i, rst_n_i;
    logic        fetch_valid_i, flush_i, ex_ready_i;
    logic [31:0] fetch_instr_i, fetch_pc_i;

    logic        fetch_ready_o, ex_valid_o, br_sig_o, reg_wr_sig_o, mem_wr_sig_o, illegal_o;
    logic [31:0] ex_pc_o, imm_o;
    logic [2:0]  br_op_o, lsu_op_o;
    logic [4:0]  alu_op_o, reg_addr1_o, reg_addr2_o, reg_wr_addr_o;
    logic [1:0]  data_origin_o, data_dest_o;
    logic [2:0]  iq_count_o;

    logic        n_fetch_ready, n_ex_valid, n_br_sig, n_reg_wr_sig, n_mem_wr_sig, n_illegal;
    logic [31:0] n_ex_pc, n_imm;
    logic [2:0]  n_br_op, n_lsu_op;
    logic [4:0]  n_alu_op, n_reg_addr1, n_reg_addr2, n_reg_wr_addr;
    logic [1:0]  n_data_origin, n_data_dest;
    logic [2:0]  n_iq_count;

    int vectors     = 0;
    int miscompares = 0;

    decode_stage #(.IQ_DEPTH(4), .EN_MEXT(1'b1)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
        .ex_pc_o(ex_pc_o), .br_sig_o(br_sig_o), .br_op_o(br_op_o),
        .lsu_op_o(lsu_op_o), .alu_op_o(alu_op_o), .data_origin_o(data_origin_o),
        .data_dest_o(data_dest_o), .imm_o(imm_o), .reg_addr1_o(reg_addr1_o),
        .reg_addr2_o(reg_addr2_o), .reg_wr_addr_o(reg_wr_addr_o),
        .reg_wr_sig_o(reg_wr_sig_o), .mem_wr_sig_o(mem_wr_sig_o),
        .illegal_o(illegal_o), .iq_count_o(iq_count_o)
    );

    decode_stage #(.IQ_DEPTH(4), .EN_MEXT(1'b0)) u_dut_nm (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(n_fetch_ready),
        .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(n_ex_valid),
        .ex_pc_o(n_ex_pc), .br_sig_o(n_br_sig), .br_op_o(n_br_op),
        .lsu_op_o(n_lsu_op), .alu_op_o(n_alu_op), .data_origin_o(n_data_origin),
        .data_dest_o(n_data_dest), .imm_o(n_imm), .reg_addr1_o(n_reg_addr1),
        .reg_addr2_o(n_reg_addr2), .reg_wr_addr_o(n_reg_wr_addr),
        .reg_wr_sig_o(n_reg_wr_sig), .mem_wr_sig_o(n_mem_wr_sig),
        .illegal_o(n_illegal), .iq_count_o(n_iq_count)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        fetch_valid_i = 1'b1;
        fetch_instr_i = instr;
        fetch_pc_i    = pc;
    endtask

    task automatic idle();
        fetch_valid_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
        fetch_valid_i = 1'b0; fetch_instr_i = '0; fetch_pc_i = '0;

        // Reset state
        #2;
        check("rst_valid", ex_valid_o, 0);
        check("rst_count", iq_count_o, 0);
        check("rst_pc", ex_pc_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_ctrl", {br_sig_o, br_op_o, lsu_op_o, alu_op_o, data_origin_o, data_dest_o,
                           reg_addr1_o, reg_addr2_o, reg_wr_addr_o, reg_wr_sig_o, mem_wr_sig_o}, 0);
        check("rst_illegal", illegal_o, 0);
        #10 rst_n_i = 1'b1;
        #1;
        check("rst_ready", fetch_ready_o, 1);

        // Basic decode: addi x1,x0,5
        offer(32'h0050_0093, 32'h100);
        tick();
        idle();
        check("addi_count_after_push", iq_count_o, 1);
        check("addi_not_yet_valid", ex_valid_o, 0);
        tick();
        check("addi_valid", ex_valid_o, 1);
        check("addi_pc", ex_pc_o, 32'h100);
        check("addi_alu", alu_op_o, ALU_ADD);
        check("addi_imm", imm_o, 5);
        check("addi_ra1", reg_addr1_o, 0);
        check("addi_wa", reg_wr_addr_o, 1);
        check("addi_wr", reg_wr_sig_o, 1);
        check("addi_origin", data_origin_o, ORIG_RI);
        check("addi_dest", data_dest_o, DEST_ALU);
        check("addi_count_after_pop", iq_count_o, 0);
        tick();
        check("empty_drops_valid", ex_valid_o, 0);

        // Load-use: lw x2,0(x1) then add x3,x2,x1
        offer(32'h0000_A103, 32'h200);
        tick();
        offer(32'h0011_01B3, 32'h204);
        tick();
        idle();
        check("lw_valid", ex_valid_o, 1);
        check("lw_dest", data_dest_o, DEST_MEM);
        check("lw_lsu", lsu_op_o, 2);
        check("lw_wa", reg_wr_addr_o, 2);
        check("lw_ra1", reg_addr1_o, 1);
        tick();
        check("lu_bubble", ex_valid_o, 0);
        check("lu_bubble_count", iq_count_o, 1);
        tick();
        check("add_valid", ex_valid_o, 1);
        check("add_pc", ex_pc_o, 32'h204);
        check("add_ra1", reg_addr1_o, 2);
        check("add_ra2", reg_addr2_o, 1);
        check("add_wa", reg_wr_addr_o, 3);
        check("add_origin", data_origin_o, ORIG_RR);

        // No bubble: lw x2,0(x1) then addi x3,x0,1
        offer(32'h0000_A103, 32'h300);
        tick();
        offer(32'h0010_0193, 32'h304);
        tick();
        idle();
        check("lw2_pc", ex_pc_o, 32'h300);
        tick();
        check("nobubble_valid", ex_valid_o, 1);
        check("nobubble_pc", ex_pc_o, 32'h304);
        check("nobubble_imm", imm_o, 1);

        // M extension: mul x5,x6,x7 on both builds
        offer(32'h0273_02B3, 32'h400);
        tick();
        idle();
        tick();
        check("mul_alu", alu_op_o, ALU_MUL);
        check("mul_illegal", illegal_o, 0);
        check("mul_regs", {reg_addr1_o, reg_addr2_o, reg_wr_addr_o, reg_wr_sig_o}, {5'd6, 5'd7, 5'd5, 1'b1});
        check("nm_valid", n_ex_valid, 1);
        check("nm_pc", n_ex_pc, 32'h400);
        check("nm_illegal", n_illegal, 1);
        check("nm_wr", n_reg_wr_sig, 0);
        check("nm_ctrl_zero", {n_br_sig, n_br_op, n_lsu_op, n_alu_op, n_data_origin, n_data_dest,
                               n_reg_addr1, n_reg_addr2, n_reg_wr_addr, n_mem_wr_sig}, 0);
        check("nm_imm", n_imm, 0);
        check("nm_count_ready", {n_iq_count, n_fetch_ready}, {3'd0, 1'b1});

        // Illegal opcode
        offer(32'hFFFF_FFFF, 32'h500);
        tick();
        idle();
        tick();
        check("ill_valid", ex_valid_o, 1);
        check("ill_flag", illegal_o, 1);
        check("ill_sigs", {reg_wr_sig_o, mem_wr_sig_o, br_sig_o}, 0);
        check("ill_pc", ex_pc_o, 32'h500);

        // Store and branch back-to-back: sw x2,8(x1); beq x1,x2,-4
        offer(32'h0020_A423, 32'h600);
        tick();
        offer(32'hFE20_8EE3, 32'h604);
        tick();
        idle();
        check("sw_memwr", {mem_wr_sig_o, reg_wr_sig_o, data_dest_o}, {1'b1, 1'b0, DEST_NONE});
        check("sw_imm", imm_o, 8);
        check("sw_ra2", reg_addr2_o, 2);
        tick();
        check("beq_pc", ex_pc_o, 32'h604);
        check("beq_br", {br_sig_o, br_op_o, reg_wr_sig_o}, {1'b1, 3'd0, 1'b0});
        check("beq_imm", imm_o, 32'hFFFF_FFFC);
        tick();
        check("beq_drain", ex_valid_o, 0);

        // Backpressure: five addi words with execute stalled
        ex_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            offer({12'(k + 1), 5'd0, 3'd0, 5'(k + 1), 7'h13}, 32'h700 + 32'(4 * k));
            tick();
        end
        check("bp_full_count", iq_count_o, 4);
        check("bp_ready_low", fetch_ready_o, 0);
        check("bp_head_pc", ex_pc_o, 32'h700);
        offer(32'h0630_0313, 32'h7FC);
        tick();
        tick();
        check("bp_count_held", iq_count_o, 4);
        check("bp_pc_stable", ex_pc_o, 32'h700);
        check("bp_imm_stable", imm_o, 1);
        check("bp_valid_stable", ex_valid_o, 1);
        idle();
        ex_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("bp_order_pc", ex_pc_o, 32'h700 + 32'(4 * k));
            check("bp_order_imm", imm_o, 32'(k + 1));
        end
        check("bp_drained_count", iq_count_o, 0);
        tick();
        check("bp_no_dup", ex_valid_o, 0);

        // Flush with three queued words and a valid output
        ex_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            offer(32'h0010_0093, 32'h800 + 32'(4 * k));
            tick();
        end
        check("fl_pre_count", iq_count_o, 3);
        check("fl_pre_valid", ex_valid_o, 1);
        flush_i = 1'b1;
        offer(32'h0070_0393, 32'h8F0);
        #1;
        check("fl_ready_low", fetch_ready_o, 0);
        tick();
        flush_i = 1'b0;
        idle();
        ex_ready_i = 1'b1;
        check("fl_count", iq_count_o, 0);
        check("fl_valid", ex_valid_o, 0);
        tick();
        check("fl_dropped", ex_valid_o, 0);
        offer(32'h0050_0093, 32'h900);
        tick();
        idle();
        tick();
        check("fl_next_pc", ex_pc_o, 32'h900);
        check("fl_next_imm", imm_o, 5);

        // Flush clears ld_rd: lw x2 issues, flush, then add x3,x2,x1 issues without a bubble
        offer(32'h0000_A103, 32'hA00);
        tick();
        idle();
        tick();
        check("fl_lw_pc", ex_pc_o, 32'hA00);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        offer(32'h0011_01B3, 32'hA04);
        tick();
        idle();
        tick();
        check("fl_ldrd_valid", ex_valid_o, 1);
        check("fl_ldrd_pc", ex_pc_o, 32'hA04);

        // Asynchronous reset mid-transfer
        offer(32'h0050_0093, 32'hB00);
        tick();
        idle();
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_count", iq_count_o, 0);
        check("arst_valid", ex_valid_o, 0);
        check("arst_pc", ex_pc_o, 0);
        #1 rst_n_i = 1'b1;
        tick();
        check("arst_no_survivor", ex_valid_o, 0);
        check("arst_ready", fetch_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
